// File: rtl/dma_slv_pkg.sv
// Shared definitions for the DMA control-register AXI responder.
// FSM state encodings, register offsets, response/burst codes, byte-merge helper.
// Combinational helpers only; no state lives here.
package dma_slv_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t WDATA = 2'd1;
  localparam state_t WRESP = 2'd2;
  localparam state_t RDATA = 2'd3;

  localparam logic [31:0] CTRL_OFS   = 32'h00;
  localparam logic [31:0] SRC_OFS    = 32'h04;
  localparam logic [31:0] DST_OFS    = 32'h08;
  localparam logic [31:0] LEN_OFS    = 32'h0C;
  localparam logic [31:0] STATUS_OFS = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // True when the offset lands on one of the five implemented registers.
  function automatic logic ofs_hit(input logic [31:0] ofs);
    return (ofs == CTRL_OFS) || (ofs == SRC_OFS) || (ofs == DST_OFS) ||
           (ofs == LEN_OFS)  || (ofs == STATUS_OFS);
  endfunction

  // Replace only the byte lanes enabled in strb.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dma_axi_slave_if.sv
// AXI4 slave-port bundle between the interconnect and the DMA register responder.
// Pure wiring, no latency.
// Valid/ready on every channel; direction split by the slave/master modports.
interface dma_axi_slave_if #(parameter int ID_W = 8);
  logic [ID_W-1:0] S_AWID;
  logic [31:0]     S_AWAddr;
  logic [3:0]      S_AWLen;
  logic [2:0]      S_AWSize;
  logic [1:0]      S_AWBurst;
  logic            S_AWValid;
  logic            S_AWReady;
  logic [31:0]     S_WData;
  logic [3:0]      S_WStrb;
  logic            S_WLast;
  logic            S_WValid;
  logic            S_WReady;
  logic [ID_W-1:0] S_BID;
  logic [1:0]      S_BResp;
  logic            S_BValid;
  logic            S_BReady;
  logic [ID_W-1:0] S_ARID;
  logic [31:0]     S_ARAddr;
  logic [3:0]      S_ARLen;
  logic [2:0]      S_ARSize;
  logic [1:0]      S_ARBurst;
  logic            S_ARValid;
  logic            S_ARReady;
  logic [ID_W-1:0] S_RID;
  logic [31:0]     S_RData;
  logic [1:0]      S_RResp;
  logic            S_RLast;
  logic            S_RValid;
  logic            S_RReady;

  modport slave (
    input  S_AWID, S_AWAddr, S_AWLen, S_AWSize, S_AWBurst, S_AWValid,
    output S_AWReady,
    input  S_WData, S_WStrb, S_WLast, S_WValid,
    output S_WReady,
    output S_BID, S_BResp, S_BValid,
    input  S_BReady,
    input  S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst, S_ARValid,
    output S_ARReady,
    output S_RID, S_RData, S_RResp, S_RLast, S_RValid,
    input  S_RReady
  );

  modport master (
    output S_AWID, S_AWAddr, S_AWLen, S_AWSize, S_AWBurst, S_AWValid,
    input  S_AWReady,
    output S_WData, S_WStrb, S_WLast, S_WValid,
    input  S_WReady,
    input  S_BID, S_BResp, S_BValid,
    output S_BReady,
    output S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst, S_ARValid,
    input  S_ARReady,
    input  S_RID, S_RData, S_RResp, S_RLast, S_RValid,
    output S_RReady
  );
endinterface

// File: rtl/dma_slv_regfile.sv
// DMA control registers (CTRL/SRC/DST/LEN) plus the sticky done bit in STATUS.
// Writes land on the clock edge after we; reads are combinational from rd_ofs.
// No backpressure; DMA_SLV_AUTOCLR_EN makes DMAEN self-clear on the rising done level.
module dma_slv_regfile
  import dma_slv_pkg::*;
#(
  parameter int OFS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [OFS_W-1:0] wr_ofs,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  input  logic [OFS_W-1:0] rd_ofs,
  output logic [31:0]      rd_data,
  output logic             rd_hit,
  input  logic             irq_in,
  output logic             en,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [31:0]      len,
  output logic             done
);

  logic [31:0] wofs;
  logic [31:0] rofs;
  logic        clr;

  assign wofs = 32'(wr_ofs);
  assign rofs = 32'(rd_ofs);
  // STATUS clear only counts when the low byte lane is enabled.
  assign clr  = we && (wofs == STATUS_OFS) && wr_strb[0] && wr_data[0];

`ifdef DMA_SLV_AUTOCLR_EN
  logic irq_q;
`endif

  // Register updates from CPU writes and from the DMA done level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en   <= 1'b0;
      src  <= '0;
      dst  <= '0;
      len  <= '0;
      done <= 1'b0;
`ifdef DMA_SLV_AUTOCLR_EN
      irq_q <= 1'b0;
`endif
    end else begin
      if (we && (wofs == CTRL_OFS) && wr_strb[0]) en <= wr_data[0];
`ifdef DMA_SLV_AUTOCLR_EN
      irq_q <= irq_in;
      // One CPU launch buys exactly one transfer.
      if (irq_in && !irq_q) en <= 1'b0;
`endif
      if (we && (wofs == SRC_OFS)) src <= byte_merge(src, wr_data, wr_strb);
      if (we && (wofs == DST_OFS)) dst <= byte_merge(dst, wr_data, wr_strb);
      if (we && (wofs == LEN_OFS)) len <= byte_merge(len, wr_data, wr_strb);
      // A set arriving with a clear wins so no completion is lost.
      if (irq_in)   done <= 1'b1;
      else if (clr) done <= 1'b0;
    end
  end

  // Read mux; unmapped offsets return zero with rd_hit low.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    case (rofs)
      CTRL_OFS:   rd_data = {31'b0, en};
      SRC_OFS:    rd_data = src;
      DST_OFS:    rd_data = dst;
      LEN_OFS:    rd_data = len;
      STATUS_OFS: rd_data = {31'b0, done};
      default:    rd_hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/dma_axi_slave.sv
// AXI4 responder exposing the DMA engine control registers to the CPU.
// AW/AR accepted combinationally in IDLE; B and first R beat one cycle after the last W / AR handshake.
// One transaction at a time; B and R held until ready. Build option: DMA_SLV_AUTOCLR_EN.
module dma_axi_slave
  import dma_slv_pkg::*;
#(
  parameter int ID_W  = 8,
  parameter int OFS_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  dma_axi_slave_if.slave s,
  input  logic        DMA_interrupt,
  output logic        DMAEN,
  output logic [31:0] DMASRC,
  output logic [31:0] DMADST,
  output logic [31:0] DMALEN,
  output logic        dma_irq
);

  state_t          state;
  logic [ID_W-1:0] id_q;
  logic [OFS_W-1:0] ofs_q;
  logic [3:0]      len_q;
  logic [3:0]      cnt_q;
  logic            incr_q;
  logic            err_q;
  logic            bvalid_q;
  logic            rvalid_q;
  logic            rlast_q;
  logic [1:0]      rresp_q;
  logic [31:0]     rdata_q;

  logic            in_idle;
  logic            aw_hs;
  logic            ar_hs;
  logic            w_hs;
  logic            r_hs;
  logic [OFS_W-1:0] ofs_nxt;
  logic [OFS_W-1:0] rd_ofs;
  logic [31:0]     rd_data;
  logic            rd_hit;
  logic            unused_bits;

  assign unused_bits = ^{s.S_AWSize, s.S_ARSize, s.S_AWAddr[31:OFS_W], s.S_ARAddr[31:OFS_W]};

  // Ready is also gated by rst so nothing is accepted while held in reset.
  assign in_idle     = (state == IDLE) && rst;
  assign s.S_AWReady = in_idle;
  assign s.S_ARReady = in_idle && !s.S_AWValid;
  assign s.S_WReady  = (state == WDATA);
  assign aw_hs       = s.S_AWValid && s.S_AWReady;
  assign ar_hs       = s.S_ARValid && s.S_ARReady;
  assign w_hs        = s.S_WValid && s.S_WReady;
  assign r_hs        = rvalid_q && s.S_RReady;

  assign ofs_nxt = incr_q ? ofs_q + OFS_W'(4) : ofs_q;
  // Look ahead so the next R beat is ready on the edge of the current handshake.
  assign rd_ofs  = (state == IDLE) ? s.S_ARAddr[OFS_W-1:0] : ofs_nxt;

  assign s.S_BValid = bvalid_q;
  assign s.S_BID    = id_q;
  assign s.S_BResp  = (bvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s.S_RValid = rvalid_q;
  assign s.S_RID    = id_q;
  assign s.S_RData  = rdata_q;
  assign s.S_RResp  = rresp_q;
  assign s.S_RLast  = rlast_q;

  dma_slv_regfile #(.OFS_W(OFS_W)) u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (w_hs),
    .wr_ofs  (ofs_q),
    .wr_data (s.S_WData),
    .wr_strb (s.S_WStrb),
    .rd_ofs  (rd_ofs),
    .rd_data (rd_data),
    .rd_hit  (rd_hit),
    .irq_in  (DMA_interrupt),
    .en      (DMAEN),
    .src     (DMASRC),
    .dst     (DMADST),
    .len     (DMALEN),
    .done    (dma_irq)
  );

  // Transaction FSM: address capture, W beat walk, B response, R beat walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      id_q     <= '0;
      ofs_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      incr_q   <= 1'b0;
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q   <= s.S_AWID;
            ofs_q  <= s.S_AWAddr[OFS_W-1:0];
            len_q  <= s.S_AWLen;
            incr_q <= (s.S_AWBurst == BURST_INCR);
            cnt_q  <= '0;
            err_q  <= 1'b0;
            state  <= WDATA;
          end else if (ar_hs) begin
            id_q     <= s.S_ARID;
            ofs_q    <= s.S_ARAddr[OFS_W-1:0];
            len_q    <= s.S_ARLen;
            incr_q   <= (s.S_ARBurst == BURST_INCR);
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            rlast_q  <= (s.S_ARLen == 4'd0);
            state    <= RDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            ofs_q <= ofs_nxt;
            cnt_q <= cnt_q + 4'd1;
            // Unmapped beat, or the announced final beat arrives without WLast.
            if (!ofs_hit(32'(ofs_q)) || ((cnt_q == len_q) && !s.S_WLast)) err_q <= 1'b1;
            if (s.S_WLast) begin
              bvalid_q <= 1'b1;
              state    <= WRESP;
            end
          end
        end
        WRESP: begin
          if (s.S_BReady) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        RDATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state    <= IDLE;
            end else begin
              ofs_q   <= ofs_nxt;
              cnt_q   <= cnt_q + 4'd1;
              rdata_q <= rd_data;
              rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
              rlast_q <= ((cnt_q + 4'd1) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_axi_slave.sv
// Directed bench for dma_axi_slave: single-beat vector table plus burst, interrupt,
// write/read collision and mid-burst reset sequences.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_dma_axi_slave;
  import dma_slv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq = 1'b0;
  logic        dmaen, dma_irq;
  logic [31:0] dmasrc, dmadst, dmalen;

  dma_axi_slave_if #(.ID_W(8)) axi();

  dma_axi_slave #(.ID_W(8), .OFS_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s             (axi),
    .DMA_interrupt (irq),
    .DMAEN         (dmaen),
    .DMASRC        (dmasrc),
    .DMADST        (dmadst),
    .DMALEN        (dmalen),
    .dma_irq       (dma_irq)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [31:0] wdat [4];
  logic [31:0] rdat [4];
  logic [1:0]  rrsp [4];
  logic        rlst [4];
  logic [7:0]  rid0;
  logic        rstable;
  logic        rvalid_after;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: got no handshake expected one within 20 cycles", name);
  endtask

  // Starts and ends 1ns after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input int nb,
                          input logic [3:0] strb, input int bdly, input bit irq_last,
                          output logic [1:0] bresp, output logic [7:0] bid,
                          output logic bstable, output logic ar_rdy_at_aw);
    int t;
    logic [9:0] snap;
    axi.S_AWID = id; axi.S_AWAddr = addr; axi.S_AWLen = 4'(nb - 1);
    axi.S_AWSize = 3'd2; axi.S_AWBurst = BURST_INCR; axi.S_AWValid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi.S_AWReady && t < 20);
    if (t >= 20) timeout("aw_ready");
    ar_rdy_at_aw = axi.S_ARReady;
    @(posedge clk); #1;
    axi.S_AWValid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      axi.S_WData = wdat[i]; axi.S_WStrb = strb; axi.S_WLast = (i == nb - 1);
      axi.S_WValid = 1'b1;
      if (irq_last && i == nb - 1) irq = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!axi.S_WReady && t < 20);
      if (t >= 20) timeout("w_ready");
      @(posedge clk); #1;
      irq = 1'b0;
    end
    axi.S_WValid = 1'b0; axi.S_WLast = 1'b0;
    bstable = 1'b1;
    snap = '0;
    for (int k = 0; k < bdly; k++) begin
      @(negedge clk);
      if (k == 0) snap = {axi.S_BID, axi.S_BResp};
      else if ({axi.S_BID, axi.S_BResp} !== snap) bstable = 1'b0;
      if (!axi.S_BValid) bstable = 1'b0;
      @(posedge clk); #1;
    end
    axi.S_BReady = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi.S_BValid && t < 20);
    if (t >= 20) timeout("b_valid");
    bresp = axi.S_BResp;
    bid   = axi.S_BID;
    @(posedge clk); #1;
    axi.S_BReady = 1'b0;
  endtask

  // Starts and ends 1ns after a rising edge; stalls RReady on even beats when toggle is set.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input int nb, input bit toggle);
    int t;
    logic [34:0] snap;
    axi.S_ARID = id; axi.S_ARAddr = addr; axi.S_ARLen = 4'(nb - 1);
    axi.S_ARSize = 3'd2; axi.S_ARBurst = BURST_INCR; axi.S_ARValid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi.S_ARReady && t < 20);
    if (t >= 20) timeout("ar_ready");
    @(posedge clk); #1;
    axi.S_ARValid = 1'b0;
    rstable = 1'b1;
    for (int b = 0; b < nb; b++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!axi.S_RValid && t < 20);
      if (t >= 20) timeout("r_valid");
      snap = {axi.S_RData, axi.S_RResp, axi.S_RLast};
      if (toggle && (b % 2 == 0)) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (!axi.S_RValid || ({axi.S_RData, axi.S_RResp, axi.S_RLast} !== snap)) rstable = 1'b0;
      end
      @(posedge clk); #1;
      axi.S_RReady = 1'b1;
      @(negedge clk);
      rdat[b] = axi.S_RData; rrsp[b] = axi.S_RResp; rlst[b] = axi.S_RLast;
      if (b == 0) rid0 = axi.S_RID;
      @(posedge clk); #1;
      axi.S_RReady = 1'b0;
    end
    @(negedge clk);
    rvalid_after = axi.S_RValid;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary expected end of test before time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]  br;
    logic [7:0]  bi;
    logic        bs;
    logic        arr;
    logic [31:0] port_val;
    int t;

    vt[0] = '{32'h0000_0004, 32'h0001_0000, 4'hF, 32'h0001_0000, RESP_OKAY};
    vt[1] = '{32'h0000_0004, 32'h0000_0000, 4'hF, 32'h0000_0000, RESP_OKAY};
    vt[2] = '{32'h0000_0004, 32'hAABB_CCDD, 4'h5, 32'h00BB_00DD, RESP_OKAY};
    vt[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0001, RESP_OKAY};
    vt[4] = '{32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, RESP_OKAY};
    vt[5] = '{32'h1234_5608, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, RESP_OKAY};
    vt[6] = '{32'h0000_000C, 32'h1234_5678, 4'h8, 32'h1200_0000, RESP_OKAY};
    vt[7] = '{32'h0000_0020, 32'h0000_1234, 4'hF, 32'h0000_0000, RESP_SLVERR};

    axi.S_AWID = '0; axi.S_AWAddr = '0; axi.S_AWLen = '0; axi.S_AWSize = 3'd2;
    axi.S_AWBurst = BURST_INCR; axi.S_AWValid = 1'b0;
    axi.S_WData = '0; axi.S_WStrb = '0; axi.S_WLast = 1'b0; axi.S_WValid = 1'b0;
    axi.S_BReady = 1'b0;
    axi.S_ARID = '0; axi.S_ARAddr = '0; axi.S_ARLen = '0; axi.S_ARSize = 3'd2;
    axi.S_ARBurst = BURST_INCR; axi.S_ARValid = 1'b0;
    axi.S_RReady = 1'b0;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", axi.S_AWReady, 0);
    chk("rst_arready", axi.S_ARReady, 0);
    chk("rst_wready",  axi.S_WReady, 0);
    chk("rst_bvalid",  axi.S_BValid, 0);
    chk("rst_rvalid",  axi.S_RValid, 0);
    chk("rst_rlast",   axi.S_RLast, 0);
    chk("rst_bid_rid", {axi.S_BID, axi.S_RID, axi.S_BResp, axi.S_RResp}, 0);
    chk("rst_rdata",   axi.S_RData, 0);
    chk("rst_regs",    {dmaen, dma_irq} , 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_awready", axi.S_AWReady, 1);
    @(posedge clk); #1;

    // Single-beat write then read-back per table entry.
    for (int i = 0; i < 8; i++) begin
      wdat[0] = vt[i].wdata;
      do_write(vt[i].addr, 8'(8'h10 + i), 1, vt[i].strb, 0, 1'b0, br, bi, bs, arr);
      chk($sformatf("vec%0d_bresp", i), br, vt[i].exp_resp);
      chk($sformatf("vec%0d_bid", i), bi, 8'(8'h10 + i));
      case (vt[i].addr[7:0])
        8'h00:   port_val = {31'b0, dmaen};
        8'h04:   port_val = dmasrc;
        8'h08:   port_val = dmadst;
        8'h0C:   port_val = dmalen;
        default: port_val = vt[i].exp_rd;
      endcase
      if (vt[i].exp_resp == RESP_OKAY) chk($sformatf("vec%0d_port", i), port_val, vt[i].exp_rd);
      do_read(vt[i].addr, 8'(8'h80 + i), 1, 1'b0);
      chk($sformatf("vec%0d_rdata", i), rdat[0], vt[i].exp_rd);
      chk($sformatf("vec%0d_rresp", i), rrsp[0], vt[i].exp_resp);
      chk($sformatf("vec%0d_rlast", i), rlst[0], 1);
      chk($sformatf("vec%0d_rid", i), rid0, 8'(8'h80 + i));
    end

    // INCR write burst across CTRL..LEN with a delayed BReady.
    wdat[0] = 32'h1; wdat[1] = 32'h100; wdat[2] = 32'h200; wdat[3] = 32'h40;
    do_write(32'h0, 8'h3C, 4, 4'hF, 5, 1'b0, br, bi, bs, arr);
    chk("burst_bresp", br, RESP_OKAY);
    chk("burst_bid", bi, 8'h3C);
    chk("burst_bstable", bs, 1);
    chk("burst_dmaen", dmaen, 1);
    chk("burst_src", dmasrc, 32'h100);
    chk("burst_dst", dmadst, 32'h200);
    chk("burst_len", dmalen, 32'h40);

    // INCR read burst SRC..STATUS with RReady toggling.
    do_read(32'h04, 8'h5A, 4, 1'b1);
    chk("rburst_d0", rdat[0], 32'h100);
    chk("rburst_d1", rdat[1], 32'h200);
    chk("rburst_d2", rdat[2], 32'h40);
    chk("rburst_d3_status", rdat[3], 32'h0);
    chk("rburst_resp", {rrsp[0], rrsp[1], rrsp[2], rrsp[3]}, 8'h00);
    chk("rburst_last", {rlst[0], rlst[1], rlst[2], rlst[3]}, 4'b0001);
    chk("rburst_stable", rstable, 1);
    chk("rburst_rvalid_end", rvalid_after, 0);
    chk("rburst_rid", rid0, 8'h5A);

    // Read burst running off the end of the map.
    do_read(32'h0C, 8'h21, 3, 1'b0);
    chk("rmiss_d0", rdat[0], 32'h40);
    chk("rmiss_d2", rdat[2], 32'h0);
    chk("rmiss_resp", {rrsp[0], rrsp[1], rrsp[2]}, 6'b00_00_10);
    chk("rmiss_last", {rlst[0], rlst[1], rlst[2]}, 3'b001);

    // Interrupt pulse, clear racing a set, strobe-gated clear, real clear.
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    @(negedge clk);
    chk("irq_set", dma_irq, 1);
`ifdef DMA_SLV_AUTOCLR_EN
    chk("irq_autoclr_dmaen", dmaen, 0);
`else
    chk("irq_keep_dmaen", dmaen, 1);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("irq_sticky", dma_irq, 1);
    @(posedge clk); #1;
    wdat[0] = 32'h1;
    do_write(32'h10, 8'h44, 1, 4'hF, 0, 1'b1, br, bi, bs, arr);
    chk("irq_set_wins", dma_irq, 1);
    do_write(32'h10, 8'h45, 1, 4'hE, 0, 1'b0, br, bi, bs, arr);
    chk("irq_strb0_needed", dma_irq, 1);
    do_write(32'h10, 8'h46, 1, 4'hF, 0, 1'b0, br, bi, bs, arr);
    chk("irq_cleared", dma_irq, 0);
    do_read(32'h10, 8'h47, 1, 1'b0);
    chk("irq_status_rd", rdat[0], 0);

    // AW and AR valid together: write first, read sees the new value.
    axi.S_ARID = 8'h77; axi.S_ARAddr = 32'h08; axi.S_ARLen = 4'd0;
    axi.S_ARSize = 3'd2; axi.S_ARBurst = BURST_INCR; axi.S_ARValid = 1'b1;
    wdat[0] = 32'h5555_AAAA;
    do_write(32'h08, 8'h66, 1, 4'hF, 0, 1'b0, br, bi, bs, arr);
    chk("coll_arready_low", arr, 0);
    chk("coll_bid", bi, 8'h66);
    do_read(32'h08, 8'h77, 1, 1'b0);
    chk("coll_rdata", rdat[0], 32'h5555_AAAA);
    chk("coll_rid", rid0, 8'h77);

    // Reset asserted in the middle of a read burst.
    axi.S_ARID = 8'h12; axi.S_ARAddr = 32'h04; axi.S_ARLen = 4'd3; axi.S_ARValid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi.S_ARReady && t < 20);
    if (t >= 20) timeout("rst_ar_ready");
    @(posedge clk); #1;
    axi.S_ARValid = 1'b0;
    @(negedge clk);
    chk("mid_rvalid", axi.S_RValid, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rvalid", axi.S_RValid, 0);
    chk("mrst_rlast", axi.S_RLast, 0);
    chk("mrst_arready", axi.S_ARReady, 0);
    chk("mrst_dmaen", dmaen, 0);
    chk("mrst_src", dmasrc, 0);
    chk("mrst_dst", dmadst, 0);
    chk("mrst_len", dmalen, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_idle", axi.S_ARReady, 1);
    chk("mrst_bvalid", axi.S_BValid, 0);
    @(posedge clk); #1;
    do_read(32'h04, 8'h13, 1, 1'b0);
    chk("mrst_src_rd", rdat[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
